// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage.
//  Owns the PC, fetches one instruction at a time from imem over a req/gnt +
//  rvalid handshake (single outstanding request), and presents {pc, ins} to the
//  IF/ID register over a valid/ready handshake. Redirects from later stages
//  reload the PC and kill any fetch that is still in flight.
// Ports:
//  clk, rst        clock, synchronous active-high reset
//  redirect_valid  redirect request (branch taken / jump)
//  redirect_pc     redirect target, bits [1:0] ignored
//  imem_req        fetch request (only in REQ)
//  imem_addr       fetch address, valid while imem_req
//  imem_gnt        imem accepted the request this cycle
//  imem_rvalid     read data valid
//  imem_rdata      instruction word
//  out_valid       {out_pc, out_ins} valid for IF/ID
//  out_ready       IF/ID can accept
//  out_pc          address of presented instruction
//  out_ins         presented instruction
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_ins
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DROP  = 3'd3,
    S_VALID = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_out_ins;
  logic            w_capture;
  logic [XLEN-1:0] w_redirect_tgt;
  logic [XLEN-1:0] w_pc_seq;

  // Word-aligned redirect target and sequential successor (wraps mod 2^32).
  assign w_redirect_tgt = redirect_pc & ALIGN_MASK;
  assign w_pc_seq       = (r_pc + XLEN'(PC_STEP)) & ALIGN_MASK;

  // State, PC and presented-instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC & ALIGN_MASK;
      r_out_pc  <= '0;
      r_out_ins <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_capture) begin
        r_out_pc  <= r_pc;
        r_out_ins <= imem_rdata;
      end
    end
  end

  // Next-state / PC logic; a redirect always wins over any other event.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (redirect_valid) w_pc_nxt = w_redirect_tgt;
      end
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redirect_tgt;
          // A request granted in the redirect cycle fetched the old address.
          if (imem_gnt) w_state_nxt = S_DROP;
        end else if (imem_gnt) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redirect_tgt;
          w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          w_capture   = 1'b1;
          w_pc_nxt    = w_pc_seq;
          w_state_nxt = S_VALID;
        end
      end
      S_DROP: begin
        if (redirect_valid) w_pc_nxt = w_redirect_tgt;
        // The killed response has arrived; nothing is outstanding any more,
        // so leave even if a redirect arrives in the same cycle.
        if (imem_rvalid) w_state_nxt = S_REQ;
      end
      S_VALID: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redirect_tgt;
          w_state_nxt = S_REQ;
        end else if (out_ready) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign out_valid = (r_state == S_VALID) & ~redirect_valid;
  assign out_pc    = r_out_pc;
  assign out_ins   = r_out_ins;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed vector table for the listed corner
// cases, then random stimulus checked against a transaction-level model.
module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;

  int total;
  int bad;

  if_fetch_unit #(.RESET_PC(RPC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_ins(out_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: started = post-reset idle cycle done,
  // pending = a granted fetch awaits its response, kill = that response is
  // to be thrown away, full = an instruction is buffered for IF/ID.
  logic [31:0] m_pc, m_out_pc, m_out_ins;
  logic        m_started, m_pending, m_kill, m_full;

  typedef struct {
    logic        rst, redir;
    logic [31:0] rpc;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_ins;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic a_rst, logic a_redir, logic [31:0] a_rpc,
                              logic a_gnt, logic a_rv, logic [31:0] a_rd,
                              logic a_rdy, logic x_req, logic [31:0] x_addr,
                              logic x_val, logic [31:0] x_pc, logic [31:0] x_ins);
    vec_t v;
    v.rst = a_rst; v.redir = a_redir; v.rpc = a_rpc; v.gnt = a_gnt;
    v.rvalid = a_rv; v.rdata = a_rd; v.ready = a_rdy;
    v.e_req = x_req; v.e_addr = x_addr; v.e_valid = x_val;
    v.e_pc = x_pc; v.e_ins = x_ins;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  // Inputs change after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic a_rst, input logic a_redir, input logic [31:0] a_rpc,
                       input logic a_gnt, input logic a_rv, input logic [31:0] a_rd,
                       input logic a_rdy);
    @(negedge clk);
    rst = a_rst; redirect_valid = a_redir; redirect_pc = a_rpc;
    imem_gnt = a_gnt; imem_rvalid = a_rv; imem_rdata = a_rd; out_ready = a_rdy;
    #1;
  endtask

  task automatic model_reset();
    m_pc = RPC; m_out_pc = '0; m_out_ins = '0;
    m_started = 1'b0; m_pending = 1'b0; m_kill = 1'b0; m_full = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [31:0] tgt;
    tgt = redirect_pc & 32'hFFFF_FFFC;
    if (rst) begin
      model_reset();
    end else if (!m_started) begin
      m_started = 1'b1;
      if (redirect_valid) m_pc = tgt;
    end else if (m_full) begin
      if (redirect_valid) begin
        m_full = 1'b0; m_pc = tgt;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
    end else if (!m_pending) begin
      if (imem_gnt) begin
        m_pending = 1'b1; m_kill = redirect_valid;
      end
      if (redirect_valid) m_pc = tgt;
    end else if (imem_rvalid) begin
      m_pending = 1'b0;
      if (m_kill || redirect_valid) begin
        if (redirect_valid) m_pc = tgt;
      end else begin
        m_full = 1'b1; m_out_pc = m_pc; m_out_ins = imem_rdata;
        m_pc = m_pc + 32'd4;
      end
    end else if (redirect_valid) begin
      m_kill = 1'b1; m_pc = tgt;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
  endtask

  task automatic check_model(input int idx);
    logic e_req;
    e_req = m_started && !m_pending && !m_full;
    chk("rnd_req", idx, 32'(imem_req), 32'(e_req));
    if (e_req) chk("rnd_addr", idx, imem_addr, m_pc);
    chk("rnd_valid", idx, 32'(out_valid), 32'(m_full && !redirect_valid));
    chk("rnd_out_pc", idx, out_pc, m_out_pc);
    chk("rnd_out_ins", idx, out_ins, m_out_ins);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    model_reset();

    //   rst redir rpc           gnt rv rdata         rdy  req addr          val pc            ins
    // Reset, then normal fetch with 5-cycle stall.
    add(1, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h0,         32'h0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h0,         32'h0);
    add(0, 0, 32'h0,         1, 0, 32'h0,         1,   1, 32'h100,       0, 32'h0,         32'h0);
    add(0, 0, 32'h0,         0, 1, 32'h8C010004,  1,   0, 32'h0,         0, 32'h0,         32'h0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 32'h0,       0, 0, 32'h0,         0,   0, 32'h0,         1, 32'h100,       32'h8C010004);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         1, 32'h100,       32'h8C010004);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h104,       0, 32'h100,       32'h8C010004);
    add(0, 0, 32'h0,         1, 0, 32'h0,         1,   1, 32'h104,       0, 32'h100,       32'h8C010004);
    // Redirect in WAIT, response two cycles later is dropped.
    add(0, 1, 32'h203,       0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h100,       32'h8C010004);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h100,       32'h8C010004);
    add(0, 0, 32'h0,         0, 1, 32'h0000DEAD,  1,   0, 32'h0,         0, 32'h100,       32'h8C010004);
    add(0, 0, 32'h0,         1, 0, 32'h0,         1,   1, 32'h200,       0, 32'h100,       32'h8C010004);
    // Redirect coincident with rvalid.
    add(0, 1, 32'h200,       0, 1, 32'h11111111,  1,   0, 32'h0,         0, 32'h100,       32'h8C010004);
    add(0, 0, 32'h0,         1, 0, 32'h0,         1,   1, 32'h200,       0, 32'h100,       32'h8C010004);
    add(0, 0, 32'h0,         0, 1, 32'h22222222,  1,   0, 32'h0,         0, 32'h100,       32'h8C010004);
    // Redirect in VALID with out_ready high.
    add(0, 1, 32'h300,       0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h200,       32'h22222222);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h300,       0, 32'h200,       32'h22222222);
    add(0, 0, 32'h0,         1, 0, 32'h0,         1,   1, 32'h300,       0, 32'h200,       32'h22222222);
    // Reset in WAIT; late rvalid in IDLE ignored; PC wrap.
    add(1, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h200,       32'h22222222);
    add(0, 0, 32'h0,         0, 1, 32'h33333333,  1,   0, 32'h0,         0, 32'h0,         32'h0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h100,       0, 32'h0,         32'h0);
    add(0, 1, 32'hFFFFFFFC,  1, 0, 32'h0,         1,   1, 32'h100,       0, 32'h0,         32'h0);
    add(0, 0, 32'h0,         0, 1, 32'h0,         1,   0, 32'h0,         0, 32'h0,         32'h0);
    add(0, 0, 32'h0,         1, 0, 32'h0,         1,   1, 32'hFFFFFFFC,  0, 32'h0,         32'h0);
    add(0, 0, 32'h0,         0, 1, 32'h44444444,  1,   0, 32'h0,         0, 32'h0,         32'h0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0,         1, 32'hFFFFFFFC,  32'h44444444);
    add(0, 0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h0,         0, 32'hFFFFFFFC,  32'h44444444);
    add(0, 0, 32'h0,         0, 1, 32'h55555555,  1,   1, 32'h0,         0, 32'hFFFFFFFC,  32'h44444444);
    add(0, 0, 32'h0,         1, 0, 32'h0,         1,   1, 32'h0,         0, 32'hFFFFFFFC,  32'h44444444);

    // Settle registers out of X before the first checked row.
    drive(1, 0, 32'h0, 0, 0, 32'h0, 1); advance();
    drive(1, 0, 32'h0, 0, 0, 32'h0, 1); advance();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].gnt, tbl[i].rvalid,
            tbl[i].rdata, tbl[i].ready);
      chk("vec_req", i, 32'(imem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk("vec_addr", i, imem_addr, tbl[i].e_addr);
      chk("vec_valid", i, 32'(out_valid), 32'(tbl[i].e_valid));
      chk("vec_out_pc", i, out_pc, tbl[i].e_pc);
      chk("vec_out_ins", i, out_ins, tbl[i].e_ins);
      advance();
    end

    // Random phase against the model.
    drive(1, 0, 32'h0, 0, 0, 32'h0, 1); advance();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(63) == 0),
            ($urandom_range(7) == 0),
            $urandom(),
            ($urandom_range(1) == 1),
            ($urandom_range(1) == 1),
            $urandom(),
            ($urandom_range(3) != 0));
      check_model(n);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
